// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// FSM state encoding, trap cause codes and reset values.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] MCAUSE_EXT  = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_TMR  = 32'h8000_0007;
  localparam logic [31:0] MTVEC_RST   = 32'h0000_1000;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  localparam int MST_MIE_BIT  = 3;
  localparam int MST_MPIE_BIT = 7;
  localparam int MTIE_BIT     = 7;
  localparam int MEIE_BIT     = 11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WFI   = 2'd1,
    ST_ENTER = 2'd2,
    ST_RET   = 2'd3
  } trap_state_e;

  // MPP is hardwired to machine mode, so it always reads 2'b11.
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v               = 32'h0000_1800;
    v[MST_MIE_BIT]  = mie;
    v[MST_MPIE_BIT] = mpie;
    return v;
  endfunction

  function automatic logic [31:0] irq_pack(input logic tmr, input logic ext);
    logic [31:0] v;
    v           = '0;
    v[MTIE_BIT] = tmr;
    v[MEIE_BIT] = ext;
    return v;
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// Machine-mode CSR storage and read mux. Hardware trap/return updates take
// priority over software writes for mstatus, mepc and mcause.
module trap_csr_file
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_irq_i,
  input  logic        tmr_irq_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [11:0] csr_raddr_i,
  input  logic        hw_trap_i,
  input  logic [31:0] hw_cause_i,
  input  logic        hw_ret_i,
  input  logic        hw_epc_we_i,
  input  logic [31:0] hw_epc_i,
  output logic [31:0] csr_rdata_o,
  output logic        mst_mie_o,
  output logic        mtie_o,
  output logic        meie_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        mst_mie_q;
  logic        mst_mpie_q;
  logic        mtie_q;
  logic        meie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;

  logic wr_mstatus;
  logic wr_mie;
  logic wr_mtvec;
  logic wr_mepc;
  logic wr_mcause;

  assign wr_mstatus = csr_we_i && (csr_waddr_i == CSR_MSTATUS);
  assign wr_mie     = csr_we_i && (csr_waddr_i == CSR_MIE);
  assign wr_mtvec   = csr_we_i && (csr_waddr_i == CSR_MTVEC);
  assign wr_mepc    = csr_we_i && (csr_waddr_i == CSR_MEPC);
  assign wr_mcause  = csr_we_i && (csr_waddr_i == CSR_MCAUSE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      if (hw_trap_i) begin
        mst_mie_q  <= 1'b0;
        mst_mpie_q <= mst_mie_q;
      end else if (hw_ret_i) begin
        mst_mie_q  <= mst_mpie_q;
        mst_mpie_q <= 1'b1;
      end else if (wr_mstatus) begin
        mst_mie_q  <= csr_wdata_i[MST_MIE_BIT];
        mst_mpie_q <= csr_wdata_i[MST_MPIE_BIT];
      end

      if (wr_mie) begin
        mtie_q <= csr_wdata_i[MTIE_BIT];
        meie_q <= csr_wdata_i[MEIE_BIT];
      end

      if (wr_mtvec) begin
        mtvec_q <= csr_wdata_i & ALIGN_MASK;
      end

      if (hw_epc_we_i) begin
        mepc_q <= hw_epc_i & ALIGN_MASK;
      end else if (wr_mepc) begin
        mepc_q <= csr_wdata_i & ALIGN_MASK;
      end

      if (hw_trap_i) begin
        mcause_q <= hw_cause_i;
      end else if (wr_mcause) begin
        mcause_q <= csr_wdata_i;
      end
    end
  end

  // A same-cycle WB write to the address being read is bypassed to ID.
  always_comb begin
    csr_rdata_o = '0;
    if (csr_we_i && (csr_waddr_i == csr_raddr_i)) begin
      csr_rdata_o = csr_wdata_i;
    end else begin
      case (csr_raddr_i)
        CSR_MSTATUS: csr_rdata_o = mstatus_pack(mst_mie_q, mst_mpie_q);
        CSR_MIE:     csr_rdata_o = irq_pack(mtie_q, meie_q);
        CSR_MTVEC:   csr_rdata_o = mtvec_q;
        CSR_MEPC:    csr_rdata_o = mepc_q;
        CSR_MCAUSE:  csr_rdata_o = mcause_q;
        CSR_MIP:     csr_rdata_o = irq_pack(tmr_irq_i, ext_irq_i);
        default:     csr_rdata_o = '0;
      endcase
    end
  end

  assign mst_mie_o = mst_mie_q;
  assign mtie_o    = mtie_q;
  assign meie_o    = meie_q;
  assign mtvec_o   = mtvec_q;
  assign mepc_o    = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: interrupt acceptance, WFI sleep, MRET, and
// the pipeline stall/redirect it drives. state_o exposes the FSM for debug.
module trap_ctrl
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        wfi_i,
  input  logic        mret_i,
  input  logic        ext_irq_i,
  input  logic        tmr_irq_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] pc_new_o,
  output logic [1:0]  state_o
);

  trap_state_e state_q;
  logic        stall_q;
  logic        redirect_q;
  logic [31:0] pc_new_q;

  logic        mst_mie;
  logic        mtie;
  logic        meie;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  logic        ext_pend;
  logic        pending;
  logic        take;

  logic        run_trap;
  logic        run_wfi;
  logic        run_ret;
  logic        wfi_trap;
  logic        wfi_wake;

  logic        hw_trap;
  logic        hw_epc_we;
  logic [31:0] hw_epc;
  logic [31:0] hw_cause;

  assign ext_pend = ext_irq_i & meie;
  assign pending  = ext_pend | (tmr_irq_i & mtie);
  assign take     = pending & mst_mie;

  // Acceptance strobes; a taken interrupt squashes whatever EX holds.
  always_comb begin
    run_trap = 1'b0;
    run_wfi  = 1'b0;
    run_ret  = 1'b0;
    wfi_trap = 1'b0;
    wfi_wake = 1'b0;
    if (state_q == ST_RUN && ex_valid_i) begin
      run_trap = take;
      run_wfi  = !take && wfi_i;
      run_ret  = !take && !wfi_i && mret_i;
    end
    if (state_q == ST_WFI) begin
      wfi_trap = pending && mst_mie;
      wfi_wake = pending && !mst_mie;
    end
  end

  assign hw_trap   = run_trap | wfi_trap;
  assign hw_epc_we = run_trap | run_wfi;
  assign hw_epc    = run_trap ? ex_pc_i : (ex_pc_i + 32'd4);
  assign hw_cause  = ext_pend ? MCAUSE_EXT : MCAUSE_TMR;

  trap_csr_file u_csr (
    .clk         (clk),
    .rst_n       (rst_n),
    .ext_irq_i   (ext_irq_i),
    .tmr_irq_i   (tmr_irq_i),
    .csr_we_i    (csr_we_i),
    .csr_waddr_i (csr_waddr_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_raddr_i (csr_raddr_i),
    .hw_trap_i   (hw_trap),
    .hw_cause_i  (hw_cause),
    .hw_ret_i    (run_ret),
    .hw_epc_we_i (hw_epc_we),
    .hw_epc_i    (hw_epc),
    .csr_rdata_o (csr_rdata_o),
    .mst_mie_o   (mst_mie),
    .mtie_o      (mtie),
    .meie_o      (meie),
    .mtvec_o     (mtvec),
    .mepc_o      (mepc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      stall_q    <= 1'b0;
      redirect_q <= 1'b0;
      pc_new_q   <= '0;
    end else begin
      redirect_q <= 1'b0;
      pc_new_q   <= '0;
      case (state_q)
        ST_RUN: begin
          if (run_trap) begin
            state_q    <= ST_ENTER;
            redirect_q <= 1'b1;
            pc_new_q   <= mtvec;
          end else if (run_wfi) begin
            state_q <= ST_WFI;
            stall_q <= 1'b1;
          end else if (run_ret) begin
            state_q    <= ST_RET;
            redirect_q <= 1'b1;
            pc_new_q   <= mepc;
          end
        end
        ST_WFI: begin
          if (wfi_trap) begin
            state_q    <= ST_ENTER;
            stall_q    <= 1'b0;
            redirect_q <= 1'b1;
            pc_new_q   <= mtvec;
          end else if (wfi_wake) begin
            state_q    <= ST_RUN;
            stall_q    <= 1'b0;
            redirect_q <= 1'b1;
            pc_new_q   <= mepc;
          end
        end
        ST_ENTER: state_q <= ST_RUN;
        ST_RET:   state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign stall_o    = stall_q;
  assign redirect_o = redirect_q;
  assign pc_new_o   = pc_new_q;
  assign state_o    = state_q;

endmodule
